// File: rtl/eth_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_sw_pkg
// Description : Shared types and constants for the switch ingress port.
//               Broadcast DA, destination tag encodings, RX/TX state types,
//               the buffered word record and the DA-to-destination decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_sw_pkg;

  localparam logic [31:0] BCAST_DA  = 32'hFFFF_FFFF;

  // Destination tags: bit0 = port A, bit1 = port B. DEST_NONE marks a drop.
  localparam logic [1:0]  DEST_NONE = 2'b00;
  localparam logic [1:0]  DEST_A    = 2'b01;
  localparam logic [1:0]  DEST_B    = 2'b10;
  localparam logic [1:0]  DEST_BC   = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_BODY    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } eth_word_t;

  // Resolves a destination address to a tag; unknown addresses give DEST_NONE.
  function automatic logic [1:0] resolve_dest(input logic [31:0] da,
                                              input logic [31:0] addr_a,
                                              input logic [31:0] addr_b);
    if (da == addr_a)        return DEST_A;
    else if (da == addr_b)   return DEST_B;
    else if (da == BCAST_DA) return DEST_BC;
    else                     return DEST_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_fifo
// Description : Packet data FIFO with a speculative write pointer (words of
//               the packet being received) and a committed write pointer
//               (end of the last good packet). Only committed words are
//               visible to the reader; rewind discards the speculative tail.
// Ports       : clk, resetN     - clock, async active-low reset
//               wr_en, wr_word  - write one word (at the rewound position
//                                 when rewind is also set)
//               rewind          - drop speculative words
//               commit          - publish all words up to and including
//                                 this cycle's write
//               rd_en, rd_word  - read head of committed data
//               empty           - no committed word available
//               free_nx         - free words after this cycle's updates
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_fifo
  import eth_sw_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      wr_en,
  input  eth_word_t                 wr_word,
  input  logic                      rewind,
  input  logic                      commit,
  input  logic                      rd_en,
  output eth_word_t                 rd_word,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    free_nx
);

  localparam int AW = $clog2(DEPTH);

  eth_word_t   mem [DEPTH];

  // One extra MSB per pointer acts as the wrap flag: equal pointers mean
  // empty, pointers differing only in the MSB mean full.
  logic [AW:0] rd_ptr;
  logic [AW:0] cm_ptr;
  logic [AW:0] sp_ptr;
  logic [AW:0] sp_base;
  logic [AW:0] sp_nx;
  logic [AW:0] rd_nx;
  logic [AW:0] cm_nx;

  assign sp_base = rewind ? cm_ptr : sp_ptr;
  assign sp_nx   = sp_base + (AW+1)'(wr_en);
  assign rd_nx   = rd_ptr + (AW+1)'(rd_en);
  assign cm_nx   = commit ? sp_nx : cm_ptr;
  assign free_nx = (AW+1)'(DEPTH) - (sp_nx - rd_nx);
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign empty   = (cm_ptr == rd_ptr);

  always_ff @(posedge clk) begin
    if (wr_en) mem[sp_base[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr <= '0;
      cm_ptr <= '0;
      sp_ptr <= '0;
    end else begin
      rd_ptr <= rd_nx;
      cm_ptr <= cm_nx;
      sp_ptr <= sp_nx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_port
// Description : Store-and-forward ingress buffer for one switch port. Decodes
//               the DA, validates framing, commits good packets into the data
//               FIFO and a descriptor FIFO, and forwards each committed packet
//               to the fabric over a valid/ready handshake with a dest tag.
// Ports       : clk, resetN              - clock, async active-low reset
//               inData, inSop, inEop     - incoming word stream
//               portStall                - source must not start a packet
//               outData/outSop/outEop    - outgoing word
//               outValid, outReady       - fabric handshake
//               outDest                  - destination tag for the packet
//               dropPulse                - one cycle per discarded packet
//               goodCnt/dropCnt/stallCnt - saturating statistics, present
//                                          only with ETH_RX_STATS_EN defined
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_port
  import eth_sw_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter int          MAX_WORDS  = 16,
  parameter int          DESC_DEPTH = 4,
  parameter logic [31:0] PORTA_ADDR = 32'hAAAA_0001,
  parameter logic [31:0] PORTB_ADDR = 32'hBBBB_0002
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] inData,
  input  logic        inSop,
  input  logic        inEop,
  output logic        portStall,
  output logic [31:0] outData,
  output logic        outSop,
  output logic        outEop,
  output logic        outValid,
  input  logic        outReady,
  output logic [1:0]  outDest,
  output logic        dropPulse
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] goodCnt,
  output logic [15:0] dropCnt,
  output logic [15:0] stallCnt
`endif
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              DW        = $clog2(DESC_DEPTH);
  localparam int              LW        = $clog2(MAX_WORDS + 2);
  localparam logic [AW:0]     MIN_FREE  = (AW+1)'(MAX_WORDS);
  localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_WORDS);
  localparam logic [DW:0]     DESC_FULL = (DW+1)'(DESC_DEPTH);

  // ---------------------------------------------------------------- RX side
  rx_state_e     rx_state, rx_state_nx;
  logic [LW-1:0] rx_len, rx_len_nx;
  logic [1:0]    rx_dest, rx_dest_nx;
  logic [1:0]    da_dest;
  logic          wr_en, rewind, commit, drop;
  eth_word_t     wr_word;

  assign da_dest = resolve_dest(inData, PORTA_ADDR, PORTB_ADDR);
  assign wr_word = '{data: inData, sop: inSop, eop: inEop};

  // Write/commit/rewind must act on the edge that samples the word, so the
  // FIFO controls are decoded combinationally from state and inputs.
  always_comb begin
    wr_en       = 1'b0;
    rewind      = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    rx_state_nx = rx_state;
    rx_len_nx   = rx_len;
    rx_dest_nx  = rx_dest;
    case (rx_state)
      // A discarded oversize packet still lets a new inSop start cleanly.
      RX_IDLE, RX_DISCARD: begin
        if (inSop) begin
          if (inEop) begin
            drop        = 1'b1;           // runt
            rx_state_nx = RX_IDLE;
          end else begin
            wr_en       = 1'b1;
            rx_len_nx   = LW'(1);
            rx_dest_nx  = da_dest;
            rx_state_nx = RX_BODY;
          end
        end else if (inEop) begin
          rx_state_nx = RX_IDLE;
        end
      end
      RX_BODY: begin
        if (inSop) begin
          // Restart: the new DA overwrites the abandoned packet's space.
          rewind = 1'b1;
          drop   = 1'b1;
          if (inEop) begin
            rx_state_nx = RX_IDLE;
          end else begin
            wr_en      = 1'b1;
            rx_len_nx  = LW'(1);
            rx_dest_nx = da_dest;
          end
        end else if (rx_len == LEN_MAX) begin
          rewind      = 1'b1;
          drop        = 1'b1;
          rx_state_nx = inEop ? RX_IDLE : RX_DISCARD;
        end else if (inEop) begin
          // rx_len >= 1 here, so the packet is at least two words long.
          rx_state_nx = RX_IDLE;
          if (rx_dest == DEST_NONE) begin
            rewind = 1'b1;
            drop   = 1'b1;
          end else begin
            wr_en  = 1'b1;
            commit = 1'b1;
          end
        end else begin
          wr_en     = 1'b1;
          rx_len_nx = rx_len + LW'(1);
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_state  <= RX_IDLE;
      rx_len    <= '0;
      rx_dest   <= DEST_NONE;
      dropPulse <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      rx_len    <= rx_len_nx;
      rx_dest   <= rx_dest_nx;
      dropPulse <= drop;
    end
  end

  // -------------------------------------------------------------- data FIFO
  logic        rd_en;
  eth_word_t   rd_word;
  logic        fifo_empty;
  logic [AW:0] free_nx;

  eth_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .wr_en   (wr_en),
    .wr_word (wr_word),
    .rewind  (rewind),
    .commit  (commit),
    .rd_en   (rd_en),
    .rd_word (rd_word),
    .empty   (fifo_empty),
    .free_nx (free_nx)
  );

  // -------------------------------------------------------- descriptor FIFO
  logic [1:0]  desc_mem [DESC_DEPTH];
  logic [DW:0] desc_wp, desc_rp, desc_rp_nx;
  logic [DW:0] desc_count, desc_count_nx;
  logic        desc_pop;

  assign desc_count    = desc_wp - desc_rp;
  assign desc_rp_nx    = desc_rp + (DW+1)'(1);
  assign desc_count_nx = desc_count + (DW+1)'(commit) - (DW+1)'(desc_pop);

  always_ff @(posedge clk) begin
    if (commit) desc_mem[desc_wp[DW-1:0]] <= rx_dest;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      desc_wp <= '0;
      desc_rp <= '0;
    end else begin
      desc_wp <= desc_wp + (DW+1)'(commit);
      desc_rp <= desc_rp + (DW+1)'(desc_pop);
    end
  end

  // ---------------------------------------------------------------- TX side
  tx_state_e  tx_state;
  logic       xfer;
  logic       tx_load;
  logic [1:0] load_dest;

  assign xfer  = outValid && outReady;
  assign rd_en = tx_load;

  // tx_load moves the next FIFO word into the output register. After an eop
  // transfer the following packet loads in the same cycle when its
  // descriptor is already queued, giving back-to-back output.
  always_comb begin
    tx_load   = 1'b0;
    desc_pop  = 1'b0;
    load_dest = outDest;
    case (tx_state)
      TX_IDLE: begin
        if ((desc_count != '0) && !fifo_empty) begin
          tx_load   = 1'b1;
          load_dest = desc_mem[desc_rp[DW-1:0]];
        end
      end
      TX_SEND: begin
        if (xfer) begin
          if (outEop) begin
            desc_pop = 1'b1;
            if (desc_count >= (DW+1)'(2)) begin
              tx_load   = 1'b1;
              load_dest = desc_mem[desc_rp_nx[DW-1:0]];
            end
          end else begin
            tx_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tx_state <= TX_IDLE;
      outValid <= 1'b0;
      outData  <= '0;
      outSop   <= 1'b0;
      outEop   <= 1'b0;
      outDest  <= '0;
    end else if (tx_load) begin
      tx_state <= TX_SEND;
      outValid <= 1'b1;
      outData  <= rd_word.data;
      outSop   <= rd_word.sop;
      outEop   <= rd_word.eop;
      outDest  <= load_dest;
    end else if (xfer) begin
      tx_state <= TX_IDLE;
      outValid <= 1'b0;
      outSop   <= 1'b0;
      outEop   <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ stall
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) portStall <= 1'b0;
    else         portStall <= (free_nx < MIN_FREE) || (desc_count_nx >= DESC_FULL);
  end

`ifdef ETH_RX_STATS_EN
  // ------------------------------------------------------------- statistics
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      goodCnt  <= '0;
      dropCnt  <= '0;
      stallCnt <= '0;
    end else begin
      if (commit && (goodCnt != 16'hFFFF))     goodCnt  <= goodCnt + 16'd1;
      if (drop && (dropCnt != 16'hFFFF))       dropCnt  <= dropCnt + 16'd1;
      if (portStall && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
